// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program counter and its return-address stack.
package pc_pkg;

   localparam int unsigned PC_WIDTH_DEF    = 10;
   localparam int unsigned STACK_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      SEL_IMMED = 2'd0,
      SEL_STACK = 2'd1,
      SEL_INTR  = 2'd2,
      SEL_HOLD  = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/ret_stack.sv
// Parametrised LIFO of return addresses with push, pop and in-place top replace.
module ret_stack #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_val_i,
   output logic [WIDTH-1:0] top_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             err_o
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    top_idx;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign top_idx = IW'(count_q - CW'(1));
   assign top_o   = empty_o ? '0 : mem_q[top_idx];

   // Push+pop on an empty stack falls through to the plain-push branch.
   always_comb begin
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      err_o   = 1'b0;
      if (push_i && pop_i && !empty_o) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push_i) begin
         if (full_o) begin
            err_o = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_idx  = IW'(count_q);
            count_d = count_q + CW'(1);
         end
      end else if (pop_i) begin
         if (empty_o) err_o = 1'b1;
         else         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   // Contents are not reset; a write on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_idx] <= push_val_i;
   end

endmodule

// File: rtl/prog_counter_stack.sv
// Program counter with next-PC mux, return-address stack and sticky stack error flag.
module prog_counter_stack
   import pc_pkg::*;
#(
   parameter int unsigned             PC_WIDTH    = PC_WIDTH_DEF,
   parameter int unsigned             STACK_DEPTH = STACK_DEPTH_DEF,
   parameter logic [PC_WIDTH-1:0]     RESET_VAL   = '0,
   parameter logic [PC_WIDTH-1:0]     INTR_VEC    = '1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [PC_WIDTH-1:0] FROM_IMMED,
   input  logic [1:0]          PC_MUX_SEL,
   input  logic                PC_LD,
   input  logic                PC_INC,
   input  logic                PUSH,
   input  logic                PUSH_CUR,
   input  logic                POP,
   output logic [PC_WIDTH-1:0] PC_COUNT,
   output logic [PC_WIDTH-1:0] STACK_TOP,
   output logic                STACK_EMPTY,
   output logic                STACK_FULL,
   output logic                STACK_ERR
);

   localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

   pc_sel_t             sel;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                err_q, err_d;
   logic [PC_WIDTH-1:0] push_val;
   logic [PC_WIDTH-1:0] stk_top;
   logic [CW-1:0]       stk_count;
   logic                stk_empty, stk_full, stk_err;
   logic                ld_empty_err;

   assign sel      = pc_sel_t'(PC_MUX_SEL);
   assign push_val = PUSH_CUR ? pc_q : pc_q + PC_WIDTH'(1);

   ret_stack #(
      .WIDTH (PC_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk        (CLK),
      .rst        (RST),
      .push_i     (PUSH),
      .pop_i      (POP),
      .push_val_i (push_val),
      .top_o      (stk_top),
      .count_o    (stk_count),
      .empty_o    (stk_empty),
      .full_o     (stk_full),
      .err_o      (stk_err)
   );

   // Stack loads see the pre-pop top; an empty stack yields 0 and flags an error.
   always_comb begin
      pc_d         = pc_q;
      ld_empty_err = 1'b0;
      if (PC_LD) begin
         case (sel)
            SEL_IMMED: pc_d = FROM_IMMED;
            SEL_STACK: begin
               pc_d         = stk_top;
               ld_empty_err = (stk_count == '0);
            end
            SEL_INTR:  pc_d = INTR_VEC;
            SEL_HOLD:  pc_d = pc_q;
         endcase
      end else if (PC_INC) begin
         pc_d = pc_q + PC_WIDTH'(1);
      end
      err_d = err_q | stk_err | ld_empty_err;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q  <= RESET_VAL;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   assign PC_COUNT    = pc_q;
   assign STACK_TOP   = stk_top;
   assign STACK_EMPTY = stk_empty;
   assign STACK_FULL  = stk_full;
   assign STACK_ERR   = err_q;

endmodule
